alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO + IDLE/ISSUE/RESP sequencer that drives an external combinational ALU
// and holds each result until the consumer takes it. Optional macro: ALU_CARRY_CHAIN_EN.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_opcode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_chain,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic [2:0]  rsp_opcode,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd7;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef ALU_CARRY_CHAIN_EN
    logic        chain;
`endif
  } cmd_t;

  cmd_t            fifo_q [FIFO_DEPTH];
  cmd_t            wr_ent;
  cmd_t            head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic [2:0]      rsp_opcode_q, rsp_opcode_d;
  logic            push, pop, issue, fifo_nonempty;

  assign wr_ent.op  = cmd_opcode;
  assign wr_ent.a   = cmd_a;
  assign wr_ent.b   = cmd_b;
  assign wr_ent.cin = cmd_cin;
`ifdef ALU_CARRY_CHAIN_EN
  assign wr_ent.chain = cmd_chain;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
`endif

  // Readiness comes from the registered count only: a pop in the same cycle
  // does not open a slot for a full FIFO.
  assign cmd_ready     = (count_q < CW'(FIFO_DEPTH));
  assign push          = cmd_valid && cmd_ready && !rst;
  assign issue         = (state_q == S_ISSUE);
  assign pop           = issue;
  assign fifo_nonempty = (count_q != '0);
  assign head          = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wr_ent;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_nonempty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = (fifo_nonempty || push) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_opcode_d = rsp_opcode_q;
    if (issue) begin
      rsp_result_d = alu_result;
      rsp_cout_d   = alu_cout;
      rsp_opcode_d = head.op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_opcode_q <= rsp_opcode_d;
    end
  end

`ifdef ALU_CARRY_CHAIN_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (issue && head.op == OP_ADD) carry_d = alu_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign alu_cin = issue ? ((head.op == OP_ADD && head.chain) ? carry_q : head.cin) : 1'b0;
`else
  assign alu_cin = issue ? head.cin : 1'b0;
`endif

  // ALU inputs are forced to zero whenever nothing is being issued.
  assign alu_opcode = issue ? head.op : 3'd0;
  assign alu_a      = issue ? head.a  : 32'd0;
  assign alu_b      = issue ? head.b  : 32'd0;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_opcode = rsp_opcode_q;
  assign busy       = fifo_nonempty || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: behavioural ALU, in-order scoreboard of
// expected responses, latency/backpressure/reset checks.
module tb_alu_cmd_issuer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic        cmd_cin, cmd_chain;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic [2:0]  rsp_opcode;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic        cout;
  } exp_t;
  exp_t q[$];
  logic mcarry = 1'b0;

  alu_cmd_issuer #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_opcode(rsp_opcode), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CUT is taken as a AND NOT b; carry-out only for ADD.
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    case (op)
      3'd0: return {1'b0, ~a};
      3'd1: return {1'b0, a & b};
      3'd2: return {1'b0, a | b};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, a << b[4:0]};
      3'd5: return {1'b0, a >> b[4:0]};
      3'd6: return {1'b0, a & ~b};
      default: return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endcase
  endfunction

  always_comb begin
    logic [32:0] r;
    r = alu_f(alu_opcode, alu_a, alu_b, alu_cin);
    alu_result = r[31:0];
    alu_cout   = r[32];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic chain);
    logic        ecin;
    logic [32:0] r;
    exp_t        e;
    ecin = cin;
`ifdef ALU_CARRY_CHAIN_EN
    if (op == 3'd7 && chain) ecin = mcarry;
`else
    if (chain) ecin = cin;
`endif
    r = alu_f(op, a, b, ecin);
    if (op == 3'd7) mcarry = r[32];
    e.op = op; e.res = r[31:0]; e.cout = r[32];
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic chain);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        push_exp(op, a, b, cin, chain);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  // Single command into an idle block: checks two-cycle latency and held response.
  task automatic one_shot(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic chain,
                          input logic [31:0] eres, input logic ecout);
    rsp_ready = 1'b0;
    send(op, a, b, cin, chain);
    @(posedge clk); #1;
    chk({tag, "_issue_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_issue_op"}, 32'(alu_opcode), 32'(op));
    @(posedge clk); #1;
    chk({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_res"}, rsp_result, eres);
    chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'(ecout));
    chk({tag, "_rsp_op"}, 32'(rsp_opcode), 32'(op));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_after_vld"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_result", rsp_result, e.res);
        chk("sb_cout", 32'(rsp_cout), 32'(e.cout));
        chk("sb_opcode", 32'(rsp_opcode), 32'(e.op));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    rst = 1'b1; cmd_valid = 1'b1; cmd_opcode = 3'd7; cmd_a = '0; cmd_b = '0;
    cmd_cin = 1'b0; cmd_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_opcode), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);

    one_shot("add_wrap", 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    one_shot("shl31", 3'd4, 32'h1, 32'd31, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    one_shot("xor", 3'd3, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0);
    one_shot("cut", 3'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'hF000_F000, 1'b0);
    one_shot("add_cin", 3'd7, 32'd5, 32'd6, 1'b1, 1'b0, 32'd12, 1'b0);

    rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      send(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    drain();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_alu_b", alu_b, 32'd0);

    // Backpressure: one held in RESP, two queued, fourth stalled.
    rsp_ready = 1'b0;
    send(3'd3, 32'h0000_FFFF, 32'h1234_5678, 1'b0, 1'b0);
    send(3'd3, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    send(3'd3, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_opcode = 3'd3; cmd_a = 32'hDEAD_BEEF; cmd_b = 32'hFFFF_0000;
    held_res = 32'h1234_A987;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_held_res", rsp_result, held_res);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(3'd3, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 1'b0);
    drain();

    // Carry chain.
    one_shot("chain_a", 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef ALU_CARRY_CHAIN_EN
    one_shot("chain_b", 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1, 1'b0);
`else
    one_shot("chain_b", 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0, 1'b0);
`endif

    // Reset mid-RESP with two queued commands and the carry set.
    rsp_ready = 1'b0;
    send(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    send(3'd3, 32'h1, 32'h2, 1'b0, 1'b0);
    send(3'd3, 32'h3, 32'h4, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    mcarry = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_result", rsp_result, 32'd0);
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
    one_shot("post_rst_chain", 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
